// File: rtl/ysyx_20020207_pkg.sv
// Shared definitions for the writeback path: load funct3 codes and WBU state encoding.
package ysyx_20020207_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LSU = 2'd1,
    WRITE    = 2'd2
  } wbu_state_e;

endpackage

// File: rtl/ysyx_20020207_load_ext.sv
// Selects the addressed byte/half of a raw 32-bit load word and sign/zero extends it.
module ysyx_20020207_load_ext
  import ysyx_20020207_pkg::*;
(
  input  logic [2:0]  fn_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = raw_i[7:0];
      2'd1: byte_sel = raw_i[15:8];
      2'd2: byte_sel = raw_i[23:16];
      2'd3: byte_sel = raw_i[31:24];
      default: byte_sel = raw_i[7:0];
    endcase
    // Halfword misalignment is rejected upstream, so only bit 1 picks the half.
    half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  always_comb begin
    ext_o = raw_i;
    case (fn_i)
      LB:      ext_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      ext_o = {{16{half_sel[15]}}, half_sel};
      LBU:     ext_o = {24'd0, byte_sel};
      LHU:     ext_o = {16'd0, half_sel};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/ysyx_20020207_wbu.sv
// Writeback unit: takes one retiring instruction, waits for load data if needed,
// and drives the register-file write port plus commit/retire for one cycle.
module ysyx_20020207_wbu
  import ysyx_20020207_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_load_fn,
  input  logic [1:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  lsu_rvalid,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  rf_wen,
  output logic                  rf_commit,
  output logic                  retire,
  output logic                  spurious_rvalid
);

  wbu_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  wen_q, wen_d;
  logic [2:0]            fn_q, fn_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  spurious_q, spurious_d;
  logic [DATA_WIDTH-1:0] load_ext_data;

  ysyx_20020207_load_ext u_load_ext (
    .fn_i      (fn_q),
    .addr_lo_i (addr_lo_q),
    .raw_i     (lsu_rdata),
    .ext_o     (load_ext_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      fn_q       <= '0;
      addr_lo_q  <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wen_q      <= wen_d;
      fn_q       <= fn_d;
      addr_lo_q  <= addr_lo_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      spurious_q <= spurious_d;
    end
  end

  // The write-port registers load only on entry to WRITE, so they hold between commits.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    wen_d      = wen_q;
    fn_d       = fn_q;
    addr_lo_d  = addr_lo_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    spurious_d = spurious_q | (lsu_rvalid && (state_q != WAIT_LSU));
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rd_d      = in_rd;
          wen_d     = in_wen;
          fn_d      = in_load_fn;
          addr_lo_d = in_addr_lo;
          if (in_is_load) begin
            state_d = WAIT_LSU;
          end else begin
            waddr_d = in_rd;
            wdata_d = in_result;
            state_d = WRITE;
          end
        end
      end
      WAIT_LSU: begin
        if (lsu_rvalid) begin
          waddr_d = rd_q;
          wdata_d = load_ext_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready        = (state_q == IDLE);
    rf_commit       = (state_q == WRITE);
    retire          = (state_q == WRITE);
    rf_wen          = (state_q == WRITE) && wen_q && (rd_q != '0);
    rf_waddr        = waddr_q;
    rf_wdata        = wdata_q;
    spurious_rvalid = spurious_q;
  end

endmodule

// File: tb/tb_ysyx_20020207_wbu.sv
// Directed bench for the writeback unit with hand-computed expectations.
module tb_ysyx_20020207_wbu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        in_is_load;
  logic [2:0]  in_load_fn;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wen;
  logic        rf_commit;
  logic        retire;
  logic        spurious_rvalid;

  int checks   = 0;
  int failures = 0;

  ysyx_20020207_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rd           (in_rd),
    .in_wen          (in_wen),
    .in_is_load      (in_is_load),
    .in_load_fn      (in_load_fn),
    .in_addr_lo      (in_addr_lo),
    .in_result       (in_result),
    .lsu_rvalid      (lsu_rvalid),
    .lsu_rdata       (lsu_rdata),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .rf_wen          (rf_wen),
    .rf_commit       (rf_commit),
    .retire          (retire),
    .spurious_rvalid (spurious_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Commit-cycle check: strobes high, write port shows the expected entry.
  task automatic chk_commit(input string tag, input logic [4:0] a, input logic [31:0] d, input logic we);
    chk({tag, "_commit"}, {31'd0, rf_commit}, 32'd1);
    chk({tag, "_retire"}, {31'd0, retire}, 32'd1);
    chk({tag, "_wen"}, {31'd0, rf_wen}, {31'd0, we});
    chk({tag, "_waddr"}, {27'd0, rf_waddr}, {27'd0, a});
    chk({tag, "_wdata"}, rf_wdata, d);
    chk({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic ld,
                       input logic [2:0] fn, input logic [1:0] lo, input logic [31:0] res);
    in_valid   = 1'b1;
    in_rd      = rd;
    in_wen     = we;
    in_is_load = ld;
    in_load_fn = fn;
    in_addr_lo = lo;
    in_result  = res;
    step();
    in_valid   = 1'b0;
  endtask

  task automatic load_return(input string tag, input logic [4:0] rd, input logic [2:0] fn,
                             input logic [1:0] lo, input logic [31:0] raw, input logic [31:0] exp);
    issue(rd, 1'b1, 1'b1, fn, lo, 32'h0);
    chk({tag, "_wait_nocommit"}, {31'd0, rf_commit}, 32'd0);
    lsu_rvalid = 1'b1;
    lsu_rdata  = raw;
    step();
    lsu_rvalid = 1'b0;
    chk_commit(tag, rd, exp, 1'b1);
    step();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_rd = '0; in_wen = 1'b0; in_is_load = 1'b0;
    in_load_fn = '0; in_addr_lo = '0; in_result = '0; lsu_rvalid = 1'b0; lsu_rdata = '0;
    step(); step();
    rst = 1'b1;
    step();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_commit", {31'd0, rf_commit}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_spurious", {31'd0, spurious_rvalid}, 32'd0);

    // ALU op: commit the cycle after acceptance, ready again one cycle later.
    issue(5'd5, 1'b1, 1'b0, 3'b000, 2'b00, 32'h1234_5678);
    $display("txn alu rd=5 wdata=%h commit=%0b", rf_wdata, rf_commit);
    chk_commit("alu", 5'd5, 32'h1234_5678, 1'b1);
    step();
    chk("alu_ready_again", {31'd0, in_ready}, 32'd1);
    chk("alu_commit_drop", {31'd0, rf_commit}, 32'd0);
    chk("alu_wen_drop", {31'd0, rf_wen}, 32'd0);
    chk("alu_waddr_hold", {27'd0, rf_waddr}, 32'd5);
    chk("alu_wdata_hold", rf_wdata, 32'h1234_5678);

    // Load extension variants.
    load_return("lb", 5'd7, 3'b000, 2'b11, 32'h80FF_0000, 32'hFFFF_FF80);
    $display("txn lb wdata=%h", rf_wdata);
    load_return("lh", 5'd8, 3'b001, 2'b01, 32'h1234_F00D, 32'hFFFF_F00D);
    $display("txn lh wdata=%h", rf_wdata);
    load_return("lbu", 5'd9, 3'b100, 2'b01, 32'h1234_F00D, 32'h0000_00F0);
    $display("txn lbu wdata=%h", rf_wdata);
    load_return("lw", 5'd10, 3'b010, 2'b11, 32'hCAFE_BABE, 32'hCAFE_BABE);
    $display("txn lw wdata=%h", rf_wdata);
    load_return("fn111", 5'd11, 3'b111, 2'b01, 32'h8765_4321, 32'h8765_4321);
    $display("txn fn111 wdata=%h", rf_wdata);

    // LHU with a 10-cycle stall before the data returns.
    issue(5'd12, 1'b1, 1'b1, 3'b101, 2'b10, 32'h0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_commit", {31'd0, rf_commit}, 32'd0);
      step();
    end
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'h80FF_0000;
    step();
    lsu_rvalid = 1'b0;
    $display("txn lhu_stall wdata=%h commit=%0b", rf_wdata, rf_commit);
    chk_commit("lhu", 5'd12, 32'h0000_80FF, 1'b1);
    step();

    // Writes to x0 and with wen=0 still commit and retire.
    issue(5'd0, 1'b1, 1'b0, 3'b000, 2'b00, 32'hDEAD_BEEF);
    $display("txn x0 wen=%0b commit=%0b", rf_wen, rf_commit);
    chk_commit("x0", 5'd0, 32'hDEAD_BEEF, 1'b0);
    step();
    issue(5'd3, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0000_00A5);
    $display("txn nowen wen=%0b commit=%0b", rf_wen, rf_commit);
    chk_commit("nowen", 5'd3, 32'h0000_00A5, 1'b0);
    step();
    chk("spurious_still_clear", {31'd0, spurious_rvalid}, 32'd0);

    // Spurious rvalid in IDLE: sticky flag, no commit.
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'h5555_5555;
    step();
    lsu_rvalid = 1'b0;
    $display("txn spurious flag=%0b", spurious_rvalid);
    chk("spurious_set", {31'd0, spurious_rvalid}, 32'd1);
    chk("spurious_nocommit", {31'd0, rf_commit}, 32'd0);
    step(); step();
    chk("spurious_sticky", {31'd0, spurious_rvalid}, 32'd1);
    chk("spurious_data_ignored", rf_wdata, 32'h0000_00A5);

    // Same-cycle accept and rvalid: the load must wait for a fresh rvalid.
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'h1111_1111;
    issue(5'd13, 1'b1, 1'b1, 3'b010, 2'b00, 32'h0);
    lsu_rvalid = 1'b0;
    chk("same_wait_nocommit", {31'd0, rf_commit}, 32'd0);
    chk("same_wait_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("same_still_waiting", {31'd0, rf_commit}, 32'd0);
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'h2222_2222;
    step();
    lsu_rvalid = 1'b0;
    $display("txn same_cycle wdata=%h", rf_wdata);
    chk_commit("same", 5'd13, 32'h2222_2222, 1'b1);
    step();

    // Reset during WAIT_LSU drops the load; a late rvalid commits nothing.
    issue(5'd14, 1'b1, 1'b1, 3'b010, 2'b00, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_commit", {31'd0, rf_commit}, 32'd0);
    chk("midrst_retire", {31'd0, retire}, 32'd0);
    chk("midrst_wen", {31'd0, rf_wen}, 32'd0);
    chk("midrst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("midrst_wdata", rf_wdata, 32'd0);
    chk("midrst_spurious", {31'd0, spurious_rvalid}, 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("postrst_ready", {31'd0, in_ready}, 32'd1);
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'h3333_3333;
    step();
    lsu_rvalid = 1'b0;
    $display("txn late_rvalid commit=%0b spurious=%0b", rf_commit, spurious_rvalid);
    chk("late_nocommit", {31'd0, rf_commit}, 32'd0);
    chk("late_spurious", {31'd0, spurious_rvalid}, 32'd1);
    step();
    chk("late_nocommit2", {31'd0, rf_commit}, 32'd0);
    chk("late_wdata", rf_wdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
